// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transmit arbiter and related shared-bus blocks.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEFAULT_DW = 12;
  localparam int MAX_REQ    = 8;

  // One-hot round-robin pick: first asserted request at ptr+1, ptr+2, ... (mod nreq).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         idx;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % nreq);
      if ((k <= nreq) && (pick == '0) && req[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot pick from req starting after ptr.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick_ext           = rr_pick(req_ext, 3'(ptr), NREQ);
  end

  assign pick  = pick_ext[NREQ-1:0];
  assign valid = |pick_ext;

endmodule

// File: rtl/spi_tx_arbiter.sv
// Shares one SPI transmit channel between NREQ requesters: round-robin grant,
// LSB-first mode-0 serialization, per-source done pulse, then an inter-frame gap.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DEFAULT_DW,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(DW);

  state_e            state_q, state_d;
  logic [CW-1:0]     div_cnt_q, div_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     shreg_q, shreg_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;

  logic [NREQ-1:0]   pick;
  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [DW-1:0]     pick_word;

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PW'(i);
        pick_word = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    done_d    = '0;
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick;
          shreg_d   = pick_word;
          owner_d   = pick_idx;
          ptr_d     = pick_idx;
          cs_n_d    = 1'b0;
          mosi_d    = pick_word[0];
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (div_cnt_q == CW'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Data moves only on the falling edge so the slave sees it settled at the rise.
            sclk_d = 1'b0;
            if (bit_cnt_q == BW'(DW - 1)) begin
              cs_n_d          = 1'b1;
              mosi_d          = 1'b0;
              done_d[owner_q] = 1'b1;
              state_d         = GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = shreg_q >> 1;
              mosi_d    = shreg_q[1];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (div_cnt_q == CW'(2 * CLK_DIV - 1)) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= PW'(NREQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sclk = sclk_q;
  assign cs_n = cs_n_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: frame-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_spi_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 12;
  localparam int CD    = 4;
  localparam int FRAME = DW * 2 * CD;
  localparam int GAPL  = 2 * CD;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req   = '0;
  logic [NREQ*DW-1:0]  wdata = '0;
  logic [NREQ-1:0]     gnt, done;
  logic                busy, sclk, cs_n, mosi;

  logic [NREQ-1:0]     req2   = '0;
  logic [NREQ*DW-1:0]  wdata2 = '0;
  logic [NREQ-1:0]     gnt2, done2;
  logic                busy2, sclk2, cs_n2, mosi2;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .done(done), .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi)
  );

  spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .CLK_DIV(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata2),
    .gnt(gnt2), .done(done2), .busy(busy2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted frame is a timeline indexed by cycles since the grant.
  bit              m_active = 1'b0;
  int              m_e      = 0;
  int              m_ptr    = NREQ - 1;
  int              m_owner  = 0;
  logic [DW-1:0]   m_word   = '0;
  logic [NREQ-1:0] exp_gnt  = '0;
  logic [NREQ-1:0] exp_done = '0;
  logic            exp_busy = 1'b0;
  logic            exp_sclk = 1'b0;
  logic            exp_csn  = 1'b1;
  logic            exp_mosi = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int found;
    if (!rst_n) begin
      m_active = 1'b0;
      m_e      = 0;
      m_ptr    = NREQ - 1;
      m_owner  = 0;
      m_word   = '0;
    end else if (!m_active) begin
      found = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (found < 0 && req[(m_ptr + k) % NREQ]) found = (m_ptr + k) % NREQ;
      end
      if (found >= 0) begin
        m_active = 1'b1;
        m_e      = 0;
        m_owner  = found;
        m_ptr    = found;
        m_word   = wdata[found*DW +: DW];
      end
    end else begin
      m_e++;
      if (m_e >= FRAME + GAPL) m_active = 1'b0;
    end

    exp_gnt  = '0;
    exp_done = '0;
    exp_busy = 1'b0;
    exp_sclk = 1'b0;
    exp_csn  = 1'b1;
    exp_mosi = 1'b0;
    if (m_active) begin
      exp_busy = 1'b1;
      if (m_e == 0) exp_gnt = NREQ'(1) << m_owner;
      if (m_e < FRAME) begin
        exp_csn  = 1'b0;
        exp_sclk = ((m_e / CD) % 2) == 1;
        exp_mosi = m_word[m_e / (2 * CD)];
      end else if (m_e == FRAME) begin
        exp_done = NREQ'(1) << m_owner;
      end
    end
  end

  always @(negedge clk) begin
    check_output("cmp_gnt",  32'(gnt),  32'(exp_gnt));
    check_output("cmp_done", 32'(done), 32'(exp_done));
    check_output("cmp_busy", 32'(busy), 32'(exp_busy));
    check_output("cmp_sclk", 32'(sclk), 32'(exp_sclk));
    check_output("cmp_cs_n", 32'(cs_n), 32'(exp_csn));
    check_output("cmp_mosi", 32'(mosi), 32'(exp_mosi));
  end

  // Event logs for the default-rate instance.
  int            cyc = 0;
  int            gnt_idx[$];
  int            gnt_cyc[$];
  int            done_idx[$];
  int            rx_n = 0;
  logic [DW-1:0] rx_word = '0;
  int            cur_low = 0, last_low = 0;
  logic          prev_sclk = 1'b0, prev_csn = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin gnt_idx.push_back(i); gnt_cyc.push_back(cyc); end
      if (done[i]) done_idx.push_back(i);
    end
    if (!cs_n) begin
      cur_low++;
      if (!prev_sclk && sclk) begin
        if (rx_n < DW) rx_word[rx_n] = mosi;
        rx_n++;
      end
    end
    if (cs_n && !prev_csn) begin last_low = cur_low; cur_low = 0; end
    prev_sclk = sclk;
    prev_csn  = cs_n;
  end

  // Event logs for the CLK_DIV=1 instance.
  int            rx2_n = 0;
  logic [DW-1:0] rx2_word = '0;
  int            cur2_low = 0, last2_low = 0, done2_cnt = 0;
  logic          prev2_sclk = 1'b0, prev2_csn = 1'b1;

  always @(negedge clk) begin
    if (done2 != '0) done2_cnt++;
    if (!cs_n2) begin
      cur2_low++;
      if (!prev2_sclk && sclk2) begin
        if (rx2_n < DW) rx2_word[rx2_n] = mosi2;
        rx2_n++;
      end
    end
    if (cs_n2 && !prev2_csn) begin last2_low = cur2_low; cur2_low = 0; end
    prev2_sclk = sclk2;
    prev2_csn  = cs_n2;
  end

  function automatic int gnt_at(input int i);
    return (i < gnt_idx.size()) ? gnt_idx[i] : -1;
  endfunction

  function automatic int gcyc_at(input int i);
    return (i < gnt_cyc.size()) ? gnt_cyc[i] : -1000;
  endfunction

  function automatic int done_at(input int i);
    return (i < done_idx.size()) ? done_idx[i] : -1;
  endfunction

  task automatic clear_logs();
    gnt_idx.delete();
    gnt_cyc.delete();
    done_idx.delete();
    rx_n     = 0;
    rx_word  = '0;
    cur_low  = 0;
    last_low = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_gnt_count(input int n, input int budget);
    for (int k = 0; k < budget && gnt_idx.size() < n; k++) begin @(posedge clk); #2; end
    check_output("wait_gnt", 32'(gnt_idx.size() >= n), 32'd1);
  endtask

  task automatic wait_done_count(input int n, input int budget);
    for (int k = 0; k < budget && done_idx.size() < n; k++) begin @(posedge clk); #2; end
    check_output("wait_done", 32'(done_idx.size() >= n), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_cs_n", 32'(cs_n), 32'd1);
    check_output("rst_sclk", 32'(sclk), 32'd0);
    check_output("rst_mosi", 32'(mosi), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_gnt",  32'(gnt),  32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_logs();

    // Single request from source 0
    wdata[0 +: DW] = 12'hA5C;
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check_output("t1_gnt_latency", 32'(gnt),  32'h1);
    check_output("t1_cs_n_fall",   32'(cs_n), 32'd0);
    check_output("t1_busy",        32'(busy), 32'd1);
    req = '0;
    wait_done_count(1, 200);
    check_output("t1_rise_count", 32'(rx_n),     32'd12);
    check_output("t1_rx_word",    32'(rx_word),  32'hA5C);
    check_output("t1_cs_low_len", 32'(last_low), 32'd96);
    check_output("t1_done_owner", 32'(done_at(0)), 32'd0);
    idle_cycles(20);
    check_output("t1_done_once", 32'(done_idx.size()), 32'd1);

    // All sources requesting continuously
    apply_reset();
    wdata = {12'h008, 12'h004, 12'h002, 12'h001};
    req = 4'b1111;
    wait_gnt_count(5, 700);
    req = '0;
    for (int i = 0; i < 5; i++) check_output("t2_order", 32'(gnt_at(i)), 32'(i % 4));
    for (int i = 0; i < 4; i++) check_output("t2_spacing", 32'(gcyc_at(i + 1) - gcyc_at(i)), 32'd105);
    wait_done_count(5, 300);

    // Fairness: source 1 re-requests right after its done while source 3 waits
    apply_reset();
    wdata = {12'h333, 12'h000, 12'h111, 12'h000};
    req = 4'b1010;
    wait_gnt_count(1, 20);
    req[1] = 1'b0;
    wait_done_count(1, 200);
    req[1] = 1'b1;
    wait_gnt_count(2, 50);
    req[3] = 1'b0;
    wait_gnt_count(3, 200);
    req[1] = 1'b0;
    wait_done_count(3, 300);
    check_output("t3_first",  32'(gnt_at(0)), 32'd1);
    check_output("t3_second", 32'(gnt_at(1)), 32'd3);
    check_output("t3_third",  32'(gnt_at(2)), 32'd1);

    // Withdrawn request while busy
    apply_reset();
    wdata = '0;
    wdata[0 +: DW] = 12'h5A5;
    req = 4'b0001;
    wait_gnt_count(1, 20);
    req = '0;
    idle_cycles(30);
    req = 4'b0100;
    idle_cycles(1);
    req = '0;
    wait_done_count(1, 200);
    idle_cycles(20);
    check_output("t4_gnt_count",  32'(gnt_idx.size()),  32'd1);
    check_output("t4_done_count", 32'(done_idx.size()), 32'd1);
    check_output("t4_done_owner", 32'(done_at(0)), 32'd0);
    check_output("t4_idle_cs_n",  32'(cs_n), 32'd1);
    check_output("t4_idle_sclk",  32'(sclk), 32'd0);
    check_output("t4_idle_busy",  32'(busy), 32'd0);

    // Asynchronous reset in the middle of a frame
    apply_reset();
    wdata = '0;
    wdata[0 +: DW] = 12'hFFF;
    req = 4'b0001;
    wait_gnt_count(1, 20);
    req = '0;
    for (int k = 0; k < 200 && rx_n < 6; k++) begin @(posedge clk); #2; end
    check_output("t5_bit5_reached", 32'(rx_n >= 6), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_cs_n", 32'(cs_n), 32'd1);
    check_output("t5_rst_sclk", 32'(sclk), 32'd0);
    check_output("t5_rst_mosi", 32'(mosi), 32'd0);
    check_output("t5_rst_busy", 32'(busy), 32'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    check_output("t5_no_done", 32'(done_idx.size()), 32'd0);
    clear_logs();
    wdata[3*DW +: DW] = 12'h3C5;
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check_output("t5_gnt3", 32'(gnt), 32'h8);
    req = '0;
    wait_done_count(1, 200);
    check_output("t5_rx_word",    32'(rx_word),  32'h3C5);
    check_output("t5_rise_count", 32'(rx_n),     32'd12);
    check_output("t5_cs_low_len", 32'(last_low), 32'd96);
    check_output("t5_done_owner", 32'(done_at(0)), 32'd3);

    // CLK_DIV=1 instance
    idle_cycles(2);
    wdata2[0 +: DW] = 12'h800;
    req2 = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check_output("t6_gnt_latency", 32'(gnt2), 32'h1);
    req2 = '0;
    for (int k = 0; k < 100 && done2_cnt < 1; k++) begin @(posedge clk); #2; end
    idle_cycles(5);
    check_output("t6_done_count", 32'(done2_cnt), 32'd1);
    check_output("t6_cs_low_len", 32'(last2_low), 32'd24);
    check_output("t6_rise_count", 32'(rx2_n),     32'd12);
    check_output("t6_rx_word",    32'(rx2_word),  32'h800);

    idle_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter and sequencer that shares one 12-bit SPI transmit channel between NREQ requesters. Each requester posts a word with a req/gnt handshake. The block serializes the granted word LSB-first on sclk/cs_n/mosi, then pulses a per-requester done. It sits between on-chip command sources and the external SPI pins, and replaces per-source free-running SPI senders.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 12: frame width in bits
- CLK_DIV, 4: sclk half-period in clk cycles (≥1); one bit = 2*CLK_DIV clk
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- req  input  NREQ  request per source; held high with wdata stable until gnt
- wdata  input  NREQ*DW  word of source i at [i*DW +: DW]
- gnt  output  NREQ  one-hot, one-cycle pulse; the word of that source is captured
- done  output  NREQ  one-cycle pulse to the granted source when its frame ends
- busy  output  1  high from the gnt cycle through the end of GAP
- sclk  output  1  SPI clock, mode 0 (idles low)
- cs_n  output  1  chip select, active low
- mosi  output  1  serial data, LSB first

## Operation
- Reset values: gnt=0, done=0, busy=0, sclk=0, cs_n=1, mosi=0, state=IDLE, rr pointer=NREQ-1 (source 0 has first priority), counters=0.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: if any req is high, select the first asserted index starting at ptr+1 (mod NREQ).
  - Registered on the next edge: gnt[i]=1, shreg=wdata[i], owner=i, ptr=i, cs_n=0, mosi=wdata[i][0], sclk=0, busy=1, state=SHIFT.
- SHIFT: div_cnt counts 0..CLK_DIV-1. On each wrap, sclk toggles.
  - Falling toggle with bit_cnt<DW-1: bit_cnt++, mosi=shreg[bit_cnt+1].
  - Falling toggle with bit_cnt=DW-1: cs_n=1, mosi=0, done[owner]=1, state=GAP.
- GAP: cs_n held high for 2*CLK_DIV cycles, then state=IDLE and busy=0.
- Requesters are sampled only in IDLE. A req that drops before gnt is never granted and produces no error. req and wdata changes after gnt have no effect.
- A source re-requesting immediately after its own done gets the lowest priority if others are pending.
- Asynchronous reset mid-frame returns every output to its reset value immediately. A partial frame is abandoned with no done, and ptr returns to NREQ-1.

## Timing
- req high in IDLE -> gnt on the next posedge: 1 cycle latency. cs_n falls on the same edge as gnt.
- Frame length: cs_n low for DW*2*CLK_DIV clk cycles (96 at defaults), with DW rising sclk edges.
- mosi changes only on the cs_n falling edge and on sclk falling edges. It is stable for CLK_DIV cycles on each side of every sclk rise.
- done asserts on the cycle cs_n returns high.
- Earliest next gnt: 2*CLK_DIV+1 cycles after done (9 at defaults).
- Back-to-back throughput: one frame per DW*2*CLK_DIV + 2*CLK_DIV + 1 cycles (105 at defaults).
- Exactly one gnt bit and one done bit at most per cycle. gnt and done are never asserted together.

## Structure
- Package spi_pkg:
  - state typedef (IDLE, SHIFT, GAP) as enum logic [1:0]
  - default DW=12
  - function rr_pick(req, ptr) returning a one-hot vector
- Sub-module spi_rr_arbiter: combinational one-hot pick from req and ptr, plus a valid flag. Keep it parameterized on NREQ so other shared-bus blocks can reuse it.
- Top level holds the FSM, div/bit counters, shift register, owner/ptr registers and output flops. All outputs are registered.

## Test plan
- Reset then single request: req[0] high, wdata0=12'hA5C.
  - gnt[0] pulses 1 cycle later.
  - Rising-sclk mosi samples are 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first).
  - cs_n low for exactly 96 cycles, then done[0] pulses once.
- All four req high continuously, with words 12'h001, 12'h002, 12'h004, 12'h008.
  - Grants go in order 0,1,2,3,0.
  - Spacing of 105 cycles between gnt pulses.
- Fairness: req[1] and req[3] held high, and req[1] re-asserted right after its done.
  - Next grant goes to 3, then to 1.
- Withdrawn request: req[2] pulsed high for one cycle while busy.
  - No gnt[2] and no done[2].
  - After the current frame, the arbiter idles with cs_n=1, sclk=0.
- Reset mid-frame: rst_n low after bit 5 of 12'hFFF.
  - Same cycle: cs_n=1, sclk=0, mosi=0, busy=0.
  - No done pulse.
  - After release, req[3] alone is granted with a full 12-bit frame.
- CLK_DIV=1 build: a frame of 12'h800 holds cs_n low for 24 cycles and mosi is 1 only at the 12th sclk rise.
